// File: rtl/mda_vram_sequencer.sv
// MDA character-cell sequencer: 18-clock cell timing, display fetch strobes,
// and a req/ack arbiter that lends the VRAM port to the CPU in non-display slots.
module mda_vram_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] crtc_addr,
   output logic        crtc_clk,
   output logic [4:0]  clk_seq,
   output logic        vram_read_char,
   output logic        vram_read_att,
   output logic        charrom_read,
   output logic        disp_pipeline,
   output logic [11:0] vram_addr,
   output logic        vram_we,
   output logic [7:0]  vram_wdata,
   input  logic [7:0]  vram_data,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [11:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata
);

   // The issue cycle is the PEND cycle that lands in a CPU slot; no separate state.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PEND     = 2'd1,
      ST_COMPLETE = 2'd2
   } cpu_state_t;

   logic [4:0]  seq_r;
   logic [4:0]  seq_next_s;
   logic        char_r;
   logic        att_r;
   logic        rom_r;
   logic        pipe_r;
   logic        crtc_clk_r;
   cpu_state_t  state_r;
   logic        armed_r;
   logic        ack_r;
   logic        issue_we_r;
   logic [7:0]  rdata_r;
   logic        slot_s;
   logic        issue_s;

   // Next cell position, wrapping 17 -> 0
   always_comb begin
      seq_next_s = 5'd0;
      if (seq_r == 5'd17) begin
         seq_next_s = 5'd0;
      end else begin
         seq_next_s = seq_r + 5'd1;
      end
   end

   assign slot_s  = (seq_r >= 5'd2) && (seq_r <= 5'd16);
   assign issue_s = (state_r == ST_PEND) && slot_s;

   // VRAM port mux: attr fetch at seq 1, CPU on its issue cycle, char address otherwise
   always_comb begin
      vram_addr  = {crtc_addr, 1'b0};
      vram_we    = 1'b0;
      vram_wdata = 8'h00;
      if (seq_r == 5'd1) begin
         vram_addr = {crtc_addr, 1'b1};
      end else if (issue_s) begin
         vram_addr  = cpu_addr;
         vram_we    = cpu_we;
         vram_wdata = cpu_wdata;
      end else begin
         vram_addr = {crtc_addr, 1'b0};
      end
   end

   // Cell counter and strobes decoded from the position being entered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seq_r      <= 5'd17;
         char_r     <= 1'b0;
         att_r      <= 1'b0;
         rom_r      <= 1'b0;
         pipe_r     <= 1'b0;
         crtc_clk_r <= 1'b0;
      end else begin
         seq_r      <= seq_next_s;
         char_r     <= (seq_next_s == 5'd1);
         att_r      <= (seq_next_s == 5'd2);
         rom_r      <= (seq_next_s == 5'd3);
         pipe_r     <= (seq_next_s == 5'd3);
         crtc_clk_r <= (seq_next_s == 5'd17);
      end
   end

   // CPU handshake: a request is accepted only once per req high-phase
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         armed_r    <= 1'b1;
         ack_r      <= 1'b0;
         issue_we_r <= 1'b0;
         rdata_r    <= 8'h00;
      end else begin
         ack_r <= 1'b0;
         if (!cpu_req) begin
            armed_r <= 1'b1;
         end else begin
            armed_r <= armed_r;
         end
         case (state_r)
            ST_IDLE: begin
               if (cpu_req && armed_r) begin
                  state_r <= ST_PEND;
                  armed_r <= 1'b0;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_PEND: begin
               if (issue_s) begin
                  state_r    <= ST_COMPLETE;
                  issue_we_r <= cpu_we;
               end else begin
                  state_r <= ST_PEND;
               end
            end
            ST_COMPLETE: begin
               ack_r   <= 1'b1;
               state_r <= ST_IDLE;
               if (!issue_we_r) begin
                  rdata_r <= vram_data;
               end else begin
                  rdata_r <= rdata_r;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign clk_seq        = seq_r;
   assign vram_read_char = char_r;
   assign vram_read_att  = att_r;
   assign charrom_read   = rom_r;
   assign disp_pipeline  = pipe_r;
   assign crtc_clk       = crtc_clk_r;
   assign cpu_ack        = ack_r;
   assign cpu_rdata      = rdata_r;

endmodule

// File: tb/tb_mda_vram_sequencer.sv
// Bench for mda_vram_sequencer: cell-position model, slot-rule latency model
// and a byte-array VRAM reference for CPU reads.
module tb_mda_vram_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] crtc_addr;
   logic        crtc_clk;
   logic [4:0]  clk_seq;
   logic        vram_read_char;
   logic        vram_read_att;
   logic        charrom_read;
   logic        disp_pipeline;
   logic [11:0] vram_addr;
   logic        vram_we;
   logic [7:0]  vram_wdata;
   logic [7:0]  vram_data;
   logic        cpu_req;
   logic        cpu_we;
   logic [11:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;

   mda_vram_sequencer dut (
      .clk(clk), .reset(reset), .crtc_addr(crtc_addr), .crtc_clk(crtc_clk),
      .clk_seq(clk_seq), .vram_read_char(vram_read_char), .vram_read_att(vram_read_att),
      .charrom_read(charrom_read), .disp_pipeline(disp_pipeline), .vram_addr(vram_addr),
      .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_data(vram_data),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata)
   );

   always #5 clk = ~clk;

   logic [7:0] vram [0:4095];
   always @(posedge clk) begin
      if (vram_we) vram[vram_addr] <= vram_wdata;
      vram_data <= vram[vram_addr];
   end

   int checks = 0;
   int errors = 0;
   int ref_seq = 17;
   int cycles = 0;
   logic [7:0] ref_mem [0:4095];

   task automatic tick;
      @(posedge clk);
      if (reset) ref_seq = 17;
      else ref_seq = (ref_seq + 1) % 18;
      cycles++;
      #1;
   endtask

   task automatic wait_seq(input int s);
      for (int i = 0; i < 18 && ref_seq != s; i++) tick;
   endtask

   // Drives one CPU access and checks slot use, issue cycle, latency, data, single ack.
   task automatic cpu_access(input logic we, input logic [11:0] addr, input logic [7:0] wd,
                             output int ack_seq);
      int s1, w, exp_lat, lat;
      logic [7:0] exp_rd;
      s1 = (ref_seq + 1) % 18;
      if (s1 >= 2 && s1 <= 16) w = 0;
      else if (s1 == 17) w = 3;
      else if (s1 == 0) w = 2;
      else w = 1;
      exp_lat = 3 + w;
      exp_rd = 8'h00;
      ack_seq = -1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      lat = 0;
      for (int t = 1; t <= 10 && lat == 0; t++) begin
         tick;
         if (ref_seq == 0 || ref_seq == 1) begin
            checks++;
            if (vram_addr !== {crtc_addr, ref_seq == 1} || vram_we !== 1'b0) begin
               errors++;
               $display("FAIL slot seq=%0d addr=%h we=%b expected addr=%h we=0",
                        ref_seq, vram_addr, vram_we, {crtc_addr, ref_seq == 1});
            end
         end
         if (t == 1 + w) begin
            checks++;
            if (vram_addr !== addr || vram_we !== we || (we && vram_wdata !== wd)) begin
               errors++;
               $display("FAIL issue addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                        vram_addr, vram_we, vram_wdata, addr, we, wd);
            end
            if (we) ref_mem[addr] = wd;
            else exp_rd = ref_mem[addr];
         end
         if (cpu_ack === 1'b1) begin
            lat = t;
            ack_seq = ref_seq;
         end
      end
      checks++;
      if (lat != exp_lat) begin
         errors++;
         $display("FAIL latency got=%0d expected=%0d", lat, exp_lat);
      end
      if (!we) begin
         checks++;
         if (cpu_rdata !== exp_rd) begin
            errors++;
            $display("FAIL rdata addr=%h got=%h expected=%h", addr, cpu_rdata, exp_rd);
         end
      end
      cpu_req = 1'b0;
      tick;
      checks++;
      if (cpu_ack !== 1'b0) begin
         errors++;
         $display("FAIL extra_ack got=%b expected=0", cpu_ack);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; crtc_addr = 11'h123;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h000; cpu_wdata = 8'h00;
      for (int i = 0; i < 3; i++) tick;
      checks++;
      if ({clk_seq, vram_read_char, vram_read_att, charrom_read, disp_pipeline, crtc_clk,
           cpu_ack, vram_we} !== {5'd17, 7'b0} || cpu_rdata !== 8'h00 || vram_addr !== 12'h246) begin
         errors++;
         $display("FAIL reset_state seq=%0d ack=%b we=%b rdata=%h addr=%h expected 17/0/0/00/246",
                  clk_seq, cpu_ack, vram_we, cpu_rdata, vram_addr);
      end
   endtask

   task automatic test_display(input int n);
      logic [5:0] exp_v;
      for (int i = 0; i < n; i++) begin
         tick;
         exp_v = {ref_seq == 1, ref_seq == 2, ref_seq == 3, ref_seq == 3, ref_seq == 17, 1'b0};
         checks++;
         if (clk_seq !== ref_seq[4:0] ||
             {vram_read_char, vram_read_att, charrom_read, disp_pipeline, crtc_clk, vram_we} !== exp_v) begin
            errors++;
            $display("FAIL display seq=%0d strobes=%b expected seq=%0d strobes=%b", clk_seq,
                     {vram_read_char, vram_read_att, charrom_read, disp_pipeline, crtc_clk, vram_we},
                     ref_seq, exp_v);
         end
         if (ref_seq <= 1) begin
            checks++;
            if (vram_addr !== {crtc_addr, ref_seq == 1}) begin
               errors++;
               $display("FAIL display_addr seq=%0d got=%h expected=%h", ref_seq, vram_addr,
                        {crtc_addr, ref_seq == 1});
            end
         end
      end
   endtask

   task automatic test_cpu_write;
      int aseq;
      wait_seq(5);
      cpu_access(1'b1, 12'h800, 8'h5A, aseq);
      checks++;
      if (vram[12'h800] !== 8'h5A) begin
         errors++;
         $display("FAIL write_mem got=%h expected=5a", vram[12'h800]);
      end
   endtask

   task automatic test_cpu_read_worst;
      int aseq;
      wait_seq(8);
      cpu_access(1'b1, 12'h801, 8'hC4, aseq);
      wait_seq(16);
      cpu_access(1'b0, 12'h801, 8'h00, aseq);
      checks++;
      if (aseq != 4 || cpu_rdata !== 8'hC4) begin
         errors++;
         $display("FAIL worst_read ack_seq=%0d rdata=%h expected 4/c4", aseq, cpu_rdata);
      end
   endtask

   task automatic test_req_hold;
      int acks;
      wait_seq(8);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h801;
      acks = 0;
      for (int i = 0; i < 10 && acks == 0; i++) begin
         tick;
         if (cpu_ack === 1'b1) acks++;
      end
      for (int i = 0; i < 5; i++) begin
         tick;
         if (cpu_ack === 1'b1) acks++;
      end
      checks++;
      if (acks != 1) begin
         errors++;
         $display("FAIL hold_acks got=%0d expected=1", acks);
      end
      cpu_req = 1'b0;
      tick;
      cpu_req = 1'b1;
      acks = 0;
      for (int i = 0; i < 10 && acks == 0; i++) begin
         tick;
         if (cpu_ack === 1'b1) acks++;
      end
      checks++;
      if (acks != 1 || cpu_rdata !== 8'hC4) begin
         errors++;
         $display("FAIL rerequest acks=%0d rdata=%h expected 1/c4", acks, cpu_rdata);
      end
      cpu_req = 1'b0;
      tick;
   endtask

   task automatic test_reset_mid;
      int acks;
      wait_seq(4);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h800;
      tick;
      tick;
      reset = 1'b1;
      ref_seq = 17;
      #1;
      checks++;
      if (clk_seq !== 5'd17 || cpu_ack !== 1'b0 || vram_we !== 1'b0 || cpu_rdata !== 8'h00 ||
          {vram_read_char, vram_read_att, charrom_read, disp_pipeline, crtc_clk} !== 5'b0 ||
          vram_addr !== {crtc_addr, 1'b0}) begin
         errors++;
         $display("FAIL mid_reset seq=%0d ack=%b we=%b rdata=%h addr=%h", clk_seq, cpu_ack,
                  vram_we, cpu_rdata, vram_addr);
      end
      cpu_req = 1'b0;
      acks = 0;
      for (int i = 0; i < 3; i++) begin
         tick;
         if (cpu_ack === 1'b1) acks++;
      end
      reset = 1'b0;
      checks++;
      if (acks != 0) begin
         errors++;
         $display("FAIL aborted_ack got=%0d expected=0", acks);
      end
      test_display(20);
   endtask

   task automatic test_random;
      int aseq, gap, stop;
      for (int i = 0; i < 16; i++) begin
         cpu_access(1'b1, 12'h800 + 12'(i), 8'($urandom), aseq);
      end
      stop = cycles + 18000;
      while (cycles < stop) begin
         gap = $urandom_range(0, 12);
         for (int g = 0; g < gap; g++) begin
            tick;
            if (ref_seq == 10) crtc_addr = 11'($urandom);
            if (ref_seq <= 1) begin
               checks++;
               if (vram_addr !== {crtc_addr, ref_seq == 1} || vram_we !== 1'b0) begin
                  errors++;
                  $display("FAIL rand_slot seq=%0d addr=%h expected=%h", ref_seq, vram_addr,
                           {crtc_addr, ref_seq == 1});
               end
            end
         end
         cpu_access(1'($urandom), 12'h800 + 12'($urandom_range(0, 15)), 8'($urandom), aseq);
      end
   endtask

   initial begin
      test_reset;
      reset = 1'b0;
      test_display(54);
      test_cpu_write;
      test_cpu_read_worst;
      test_req_hold;
      test_reset_mid;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
